// File: rtl/ps_pkg.sv
// Shared constants for the pixel stream feeder: pixel width, default frame
// geometry and the two-state FSM encoding.
package ps_pkg;

    localparam int unsigned PIX_W        = 12;
    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned V_ACTIVE_DEF = 480;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

endpackage

// File: rtl/ps_skid_buf2.sv
// Two-entry in-order skid buffer. Push and pop may happen in the same cycle;
// slot0 is always the head of the queue.
module ps_skid_buf2
    import ps_pkg::*;
#(
    parameter int unsigned DATA_W = PIX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] slot0;
    logic [DATA_W-1:0] slot1;
    logic              do_pop;
    logic              do_push;

    // Pops of an empty buffer and pushes into a full, non-draining buffer are dropped.
    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign head    = slot0;

    // Storage and occupancy update.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        slot0 <= push_data;
                    end else begin
                        slot1 <= push_data;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        slot0 <= push_data;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/ps_stream_feeder.sv
// Request-driven pixel source: pulls a frame from an upstream 1-cycle-latency
// FIFO through a 2-entry skid buffer and emits one pixel per requested cycle
// with start-of-frame / end-of-line / end-of-frame markers.
module ps_stream_feeder
    import ps_pkg::*;
#(
    parameter int unsigned DATA_W   = PIX_W,
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_fifo_rd,
    input  logic              i_fifo_empty,
    input  logic [DATA_W-1:0] i_fifo_data,
    input  logic              i_req,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_sof,
    output logic              o_eol,
    output logic              o_eof
);

    localparam int unsigned FRAME_PIX = H_ACTIVE * V_ACTIVE;
    localparam int unsigned COL_W     = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int unsigned ROW_W     = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int unsigned RD_W      = $clog2(FRAME_PIX + 1);

    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic              frame_start;
    logic              active;
    logic              pop;
    logic              inflight;
    logic              rd_done;
    logic              at_eol;
    logic              at_last_row;
    logic [1:0]        count;
    logic [DATA_W-1:0] head;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [RD_W-1:0]   rd_cnt;

    assign active      = (state == ST_ACTIVE);
    assign o_busy      = active;
    assign pop         = active && i_req && (count != 2'd0);
    assign rd_done     = (rd_cnt == RD_W'(FRAME_PIX));
    assign at_eol      = (col == COL_W'(H_ACTIVE - 1));
    assign at_last_row = (row == ROW_W'(V_ACTIVE - 1));

    // Read only while the buffered plus in-flight pixels, less the one leaving
    // this cycle, leave a free slot; stop once the whole frame has been requested.
    assign o_fifo_rd = active && !i_fifo_empty && !rd_done &&
                       (({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: start a frame on i_start, finish the cycle after the last pixel.
    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_nxt   = ST_ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (o_valid && o_eof) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // A read issued this cycle returns data next cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= o_fifo_rd;
        end
    end

    // Count reads issued in the current frame.
    always_ff @(posedge i_clk) begin
        if (i_rst || frame_start) begin
            rd_cnt <= '0;
        end else if (o_fifo_rd) begin
            rd_cnt <= rd_cnt + RD_W'(1);
        end
    end

    ps_skid_buf2 #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (inflight),
        .push_data (i_fifo_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    // Column/row position of the next pixel to be emitted.
    always_ff @(posedge i_clk) begin
        if (i_rst || frame_start) begin
            col <= '0;
            row <= '0;
        end else if (pop) begin
            if (at_eol) begin
                col <= '0;
                row <= at_last_row ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Output pixel and markers, registered together; data holds between pixels.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_sof   <= 1'b0;
            o_eol   <= 1'b0;
            o_eof   <= 1'b0;
        end else begin
            o_valid <= pop;
            o_sof   <= pop && (col == '0) && (row == '0);
            o_eol   <= pop && at_eol;
            o_eof   <= pop && at_eol && at_last_row;
            if (pop) begin
                o_data <= head;
            end
        end
    end

endmodule
